pkt_rx_deframer: RTL

- Receive-side counterpart of the NoC packet processor. It consumes flits ejected by the local router port, tracks packet framing independently per virtual channel, strips the 2-bit flit type, and forwards data words to the AXI RX buffer annotated with first/last/size.
- Framing violations are detected, reported, and recovered from.
- Sits between the router local output and the AXI slave RX FIFOs, in the NoC clock domain.

---
 rtl/ravenoc_pkg.sv | 38 +++
 rtl/rx_skid_buf.sv | 48 ++++
 rtl/pkt_rx_deframer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ravenoc_pkg.sv
// rtl/ravenoc_pkg.sv - shared types and constants for the NoC RX deframer
package ravenoc_pkg;

    localparam int FLIT_WIDTH    = 34;
    localparam int FLIT_DATA     = 32;
    localparam int N_VIRT_CHN    = 2;
    localparam int VC_WIDTH      = $clog2(N_VIRT_CHN);
    localparam int PKT_WIDTH     = 8;
    localparam int PKT_POS_WIDTH = 24;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'b00,
        BODY_FLIT = 2'b01,
        TAIL_FLIT = 2'b10,
        RSVD_FLIT = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_UNEXP_FLIT   = 2'd1,
        ERR_LEN_MISMATCH = 2'd2,
        ERR_TRUNC        = 2'd3
    } err_code_t;

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_IN_PKT = 1'b1
    } vc_state_t;

    typedef struct packed {
        logic [FLIT_DATA-1:0] data;
        logic [VC_WIDTH-1:0]  vc;
        logic                 first;
        logic                 last;
        logic [PKT_WIDTH-1:0] pkt_sz;
    } s_rx_word_t;

endpackage

// File: rtl/rx_skid_buf.sv
// rtl/rx_skid_buf.sv - 2-entry skid register for deframed RX words
module rx_skid_buf
    import ravenoc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  s_rx_word_t in_word,
    output logic       out_valid,
    input  logic       out_ready,
    output s_rx_word_t out_word
);

    logic [1:0] count;
    logic [1:0] count_nxt;
    logic       push;
    logic       pop;
    s_rx_word_t skid_word;

    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_nxt = count + {1'b0, push} - {1'b0, pop};
    end

    // in_ready is registered from the occupancy, so push never happens when full
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= 2'd0;
            in_ready  <= 1'b0;
            out_word  <= '0;
            skid_word <= '0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt != 2'd2);
            if (push && (count == 2'd0 || (count == 2'd1 && pop)))
                out_word <= in_word;
            else if (pop && count == 2'd2)
                out_word <= skid_word;
            if (push && count == 2'd1 && !pop)
                skid_word <= in_word;
        end
    end

endmodule

// File: rtl/pkt_rx_deframer.sv
// rtl/pkt_rx_deframer.sv - per-VC packet framing tracker and flit-type stripper
module pkt_rx_deframer
    import ravenoc_pkg::*;
#(
    parameter int FLIT_WIDTH    = ravenoc_pkg::FLIT_WIDTH,
    parameter int FLIT_DATA     = ravenoc_pkg::FLIT_DATA,
    parameter int N_VIRT_CHN    = ravenoc_pkg::N_VIRT_CHN,
    parameter int PKT_WIDTH     = ravenoc_pkg::PKT_WIDTH,
    parameter int PKT_POS_WIDTH = ravenoc_pkg::PKT_POS_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flit_valid,
    output logic                          flit_ready,
    input  logic [FLIT_WIDTH-1:0]         flit_data,
    input  logic [$clog2(N_VIRT_CHN)-1:0] flit_vc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FLIT_DATA-1:0]          out_data,
    output logic [$clog2(N_VIRT_CHN)-1:0] out_vc,
    output logic                          out_first,
    output logic                          out_last,
    output logic [PKT_WIDTH-1:0]          out_pkt_sz,
    output logic                          err_valid,
    output logic [1:0]                    err_code,
    output logic [$clog2(N_VIRT_CHN)-1:0] err_vc
);

    vc_state_t            state_q [N_VIRT_CHN];
    logic [PKT_WIDTH-1:0] rem_q   [N_VIRT_CHN];
    logic [PKT_WIDTH-1:0] sz_q    [N_VIRT_CHN];

    logic                 accept;
    flit_type_t           ftype;
    logic [PKT_WIDTH-1:0] head_sz;
    vc_state_t            cur_state;
    logic [PKT_WIDTH-1:0] cur_rem;
    vc_state_t            nxt_state;
    logic [PKT_WIDTH-1:0] nxt_rem;
    logic [PKT_WIDTH-1:0] nxt_sz;
    logic                 emit;
    err_code_t            err;
    s_rx_word_t           word;
    s_rx_word_t           buf_word;
    err_code_t            err_code_q;

    assign accept  = flit_valid & flit_ready;
    assign ftype   = flit_type_t'(flit_data[FLIT_WIDTH-1 -: 2]);
    assign head_sz = flit_data[PKT_POS_WIDTH-1 -: PKT_WIDTH];

    always_comb begin
        cur_state   = state_q[flit_vc];
        cur_rem     = rem_q[flit_vc];
        nxt_state   = cur_state;
        nxt_rem     = cur_rem;
        nxt_sz      = sz_q[flit_vc];
        emit        = 1'b0;
        err         = ERR_NONE;
        word.data   = flit_data[FLIT_DATA-1:0];
        word.vc     = flit_vc;
        word.first  = 1'b0;
        word.last   = 1'b0;
        word.pkt_sz = sz_q[flit_vc];
        case (ftype)
            // A head always opens a fresh packet; an open one is abandoned
            HEAD_FLIT: begin
                emit        = 1'b1;
                word.first  = 1'b1;
                word.last   = (head_sz == '0);
                word.pkt_sz = head_sz;
                nxt_sz      = head_sz;
                nxt_rem     = head_sz;
                nxt_state   = (head_sz == '0) ? VC_IDLE : VC_IN_PKT;
                if (cur_state == VC_IN_PKT)
                    err = ERR_TRUNC;
            end
            BODY_FLIT: begin
                if (cur_state == VC_IDLE) begin
                    err = ERR_UNEXP_FLIT;
                end else begin
                    emit = 1'b1;
                    if (cur_rem > 1) begin
                        nxt_rem = cur_rem - 1'b1;
                    end else begin
                        word.last = 1'b1;
                        err       = ERR_LEN_MISMATCH;
                        nxt_state = VC_IDLE;
                        nxt_rem   = '0;
                    end
                end
            end
            TAIL_FLIT: begin
                if (cur_state == VC_IDLE) begin
                    err = ERR_UNEXP_FLIT;
                end else begin
                    emit      = 1'b1;
                    word.last = 1'b1;
                    nxt_state = VC_IDLE;
                    nxt_rem   = '0;
                    if (cur_rem != 1)
                        err = ERR_LEN_MISMATCH;
                end
            end
            default: err = ERR_UNEXP_FLIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_VIRT_CHN; i++) begin
                state_q[i] <= VC_IDLE;
                rem_q[i]   <= '0;
                sz_q[i]    <= '0;
            end
            err_valid  <= 1'b0;
            err_code_q <= ERR_NONE;
            err_vc     <= '0;
        end else begin
            if (accept) begin
                state_q[flit_vc] <= nxt_state;
                rem_q[flit_vc]   <= nxt_rem;
                sz_q[flit_vc]    <= nxt_sz;
            end
            err_valid  <= accept && (err != ERR_NONE);
            err_code_q <= accept ? err : ERR_NONE;
            err_vc     <= accept ? flit_vc : '0;
        end
    end

    assign err_code = err_code_q;

    rx_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept & emit),
        .in_ready  (flit_ready),
        .in_word   (word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (buf_word)
    );

    assign out_data   = buf_word.data;
    assign out_vc     = buf_word.vc;
    assign out_first  = buf_word.first;
    assign out_last   = buf_word.last;
    assign out_pkt_sz = buf_word.pkt_sz;

endmodule
